// File: rtl/conv_weight_sched_if.sv
// Weight bus between the scheduler, the serial weight source and the two conv units.
// The master side is the scheduler; the slave side is the source/sink pair.
interface conv_weight_sched_if #(
  parameter int unsigned AW = 10
);
  logic          weight_rd_en;
  logic [AW-1:0] weight_addr;
  logic          weight_bit_in;
  logic          weight_out;
  logic          weight_en_0;
  logic          weight_en_1;

  modport master (
    output weight_rd_en,
    output weight_addr,
    input  weight_bit_in,
    output weight_out,
    output weight_en_0,
    output weight_en_1
  );

  modport slave (
    input  weight_rd_en,
    input  weight_addr,
    output weight_bit_in,
    input  weight_out,
    input  weight_en_0,
    input  weight_en_1
  );
endinterface

// File: rtl/conv_weight_sched.sv
// Streams KBITS-bit binary kernels from a serial weight source to two conv units,
// round-robin arbitrated, NLOADS loads per start.
module conv_weight_sched #(
  parameter int unsigned KBITS  = 25,
  parameter int unsigned NLOADS = 8,
  parameter int unsigned AW     = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                clr,
  input  logic                req_0,
  input  logic                req_1,
  conv_weight_sched_if.master wb,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BW = $clog2(KBITS + 1);
  localparam int unsigned LW = $clog2(NLOADS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          rd_en_q, rd_en_d;
  logic          rd_dly_q, rd_dly_d;
  logic          en_0_q, en_0_d;
  logic          en_1_q, en_1_d;
  logic          wout_q, wout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state, counters and the rd_en -> weight_en pipeline.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    load_cnt_d   = load_cnt_q;
    addr_d       = addr_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_cnt_d = '0;
          addr_d     = '0;
          state_d    = S_ARB;
        end
      end
      S_ARB: begin
        if (req_0 || req_1) begin
          grant_d      = (req_0 && req_1) ? ~last_grant_q : req_1;
          last_grant_d = grant_d;
          bit_cnt_d    = '0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        addr_d    = addr_q + AW'(1);
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(KBITS - 1)) begin
          bit_cnt_d = '0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // bit_cnt doubles as the two-cycle drain timer
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(1)) begin
          bit_cnt_d  = '0;
          load_cnt_d = load_cnt_q + LW'(1);
          state_d    = (load_cnt_d == LW'(NLOADS)) ? S_DONE : S_ARB;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything; the address and arbitration history survive it.
    if (clr) begin
      state_d      = S_IDLE;
      bit_cnt_d    = '0;
      load_cnt_d   = '0;
      addr_d       = addr_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
    end

    rd_en_d  = (state_d == S_LOAD);
    rd_dly_d = rd_en_q & ~clr;
    en_0_d   = rd_dly_q & ~grant_q & ~clr;
    en_1_d   = rd_dly_q & grant_q & ~clr;
    wout_d   = wb.weight_bit_in;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      load_cnt_q   <= '0;
      addr_q       <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rd_en_q      <= 1'b0;
      rd_dly_q     <= 1'b0;
      en_0_q       <= 1'b0;
      en_1_q       <= 1'b0;
      wout_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      load_cnt_q   <= load_cnt_d;
      addr_q       <= addr_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rd_en_q      <= rd_en_d;
      rd_dly_q     <= rd_dly_d;
      en_0_q       <= en_0_d;
      en_1_q       <= en_1_d;
      wout_q       <= wout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign wb.weight_rd_en = rd_en_q;
  assign wb.weight_addr  = addr_q;
  assign wb.weight_out   = wout_q;
  assign wb.weight_en_0  = en_0_q;
  assign wb.weight_en_1  = en_1_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_conv_weight_sched.sv
// Directed bench for conv_weight_sched: three instances (NLOADS=8, NLOADS=1, AW=4)
// share control inputs; each has its own serial weight source model.
`timescale 1ns/1ps
module tb_conv_weight_sched;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic clr = 1'b0;
  logic req_0 = 1'b0;
  logic req_1 = 1'b0;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

  always #5 clk = ~clk;

  conv_weight_sched_if #(.AW(10)) wb_a ();
  conv_weight_sched_if #(.AW(10)) wb_b ();
  conv_weight_sched_if #(.AW(4))  wb_c ();

  conv_weight_sched #(.KBITS(25), .NLOADS(8), .AW(10)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start), .clr(clr), .req_0(req_0), .req_1(req_1),
    .wb(wb_a.master), .busy(busy_a), .done(done_a));
  conv_weight_sched #(.KBITS(25), .NLOADS(1), .AW(10)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start), .clr(clr), .req_0(req_0), .req_1(req_1),
    .wb(wb_b.master), .busy(busy_b), .done(done_b));
  conv_weight_sched #(.KBITS(25), .NLOADS(1), .AW(4)) u_dut_c (
    .clk(clk), .rstn(rstn), .start(start), .clr(clr), .req_0(req_0), .req_1(req_1),
    .wb(wb_c.master), .busy(busy_c), .done(done_c));

  function automatic logic src_bit(input int a);
    return ((a ^ (a >> 2) ^ (a >> 3)) & 1) != 0;
  endfunction

  // Serial weight source: returns the addressed bit one cycle after rd_en.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_a.weight_bit_in <= 1'b0;
      wb_b.weight_bit_in <= 1'b0;
      wb_c.weight_bit_in <= 1'b0;
    end else begin
      wb_a.weight_bit_in <= wb_a.weight_rd_en ? src_bit(int'(wb_a.weight_addr)) : 1'b0;
      wb_b.weight_bit_in <= wb_b.weight_rd_en ? src_bit(int'(wb_b.weight_addr)) : 1'b0;
      wb_c.weight_bit_in <= wb_c.weight_rd_en ? src_bit(int'(wb_c.weight_addr)) : 1'b0;
    end
  end

  int sel = 0;
  logic       m_rd, m_out, m_en0, m_en1, m_busy, m_done;
  logic [9:0] m_addr;

  always_comb begin
    case (sel)
      0: begin
        m_rd = wb_a.weight_rd_en; m_addr = wb_a.weight_addr; m_out = wb_a.weight_out;
        m_en0 = wb_a.weight_en_0; m_en1 = wb_a.weight_en_1; m_busy = busy_a; m_done = done_a;
      end
      1: begin
        m_rd = wb_b.weight_rd_en; m_addr = wb_b.weight_addr; m_out = wb_b.weight_out;
        m_en0 = wb_b.weight_en_0; m_en1 = wb_b.weight_en_1; m_busy = busy_b; m_done = done_b;
      end
      default: begin
        m_rd = wb_c.weight_rd_en; m_addr = {6'd0, wb_c.weight_addr}; m_out = wb_c.weight_out;
        m_en0 = wb_c.weight_en_0; m_en1 = wb_c.weight_en_1; m_busy = busy_c; m_done = done_c;
      end
    endcase
  end

  int n_tests = 0;
  int n_fail = 0;

  int   rd_addr[$];
  int   rd_cyc[$];
  int   en_cyc[$];
  logic en_out[$];
  int   grants[$];
  int   min_gap, done_cycles, addr_at_done, en0_count, en1_count;
  bit   both_en, busy_after, timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; start = 1'b0; clr = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records the selected instance's bus until one cycle after done (or the budget runs out).
  task automatic run_capture(input int max_cycles, input int poke);
    bit prev_en = 1'b0;
    bit seen_done = 1'b0;
    int gap = 0;
    rd_addr.delete(); rd_cyc.delete(); en_cyc.delete(); en_out.delete(); grants.delete();
    min_gap = 1000; done_cycles = 0; addr_at_done = -1; en0_count = 0; en1_count = 0;
    both_en = 1'b0; busy_after = 1'b1; timed_out = 1'b1;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (cyc == poke) start = 1'b1;
      tick();
      start = 1'b0;
      if (m_rd) begin rd_addr.push_back(int'(m_addr)); rd_cyc.push_back(cyc); end
      if (m_en0 && m_en1) both_en = 1'b1;
      if (m_en0 || m_en1) begin
        en_cyc.push_back(cyc);
        en_out.push_back(m_out);
        if (!prev_en) begin
          grants.push_back(m_en1 ? 1 : 0);
          if (grants.size() > 1 && gap < min_gap) min_gap = gap;
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (m_en0) en0_count++;
      if (m_en1) en1_count++;
      prev_en = m_en0 || m_en1;
      if (seen_done) begin
        if (m_done) done_cycles++;
        busy_after = m_busy;
        timed_out = 1'b0;
        break;
      end
      if (m_done) begin done_cycles++; addr_at_done = int'(m_addr); seen_done = 1'b1; end
    end
  endtask

  // Counts address, latency and data errors in the captured stream.
  function automatic int stream_bad(input int base, input int modv);
    int bad = 0;
    int ea;
    for (int k = 0; k < rd_addr.size(); k++) begin
      ea = (base + k) % modv;
      if (rd_addr[k] != ea) bad++;
      if (k >= en_cyc.size()) bad++;
      else if (en_cyc[k] != rd_cyc[k] + 2 || en_out[k] !== src_bit(ea)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    logic [15:0] outs;
    sel = 0;
    rstn = 1'b0;
    tick();
    outs = {m_rd, m_addr, m_out, m_en0, m_en1, m_busy, m_done};
    n_tests++; if (outs !== 16'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rstn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL start_after_release: busy=%b want 1", m_busy); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL clr_in_arb: busy=%b want 0", m_busy); end
    start = 1'b1; clr = 1'b1;
    tick();
    start = 1'b0; clr = 1'b0;
    n_tests++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL start_and_clr: busy=%b want 0", m_busy); end
  endtask

  task automatic test_single_load();
    sel = 1;
    do_reset();
    req_0 = 1'b1;
    pulse_start();
    run_capture(200, -1);
    req_0 = 1'b0;
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL single_timeout: no done within budget"); end
    n_tests++; if (rd_addr.size() != 25) begin n_fail++; $display("FAIL single_rd_count: got %0d want 25", rd_addr.size()); end
    n_tests++; if (stream_bad(0, 1024) != 0) begin n_fail++; $display("FAIL single_stream: %0d bad bits want 0", stream_bad(0, 1024)); end
    n_tests++; if (en0_count != 25 || en1_count != 0) begin n_fail++; $display("FAIL single_en: en0=%0d en1=%0d want 25/0", en0_count, en1_count); end
    n_tests++; if (done_cycles != 1) begin n_fail++; $display("FAIL single_done: %0d cycles want 1", done_cycles); end
    n_tests++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: %b want 0", busy_after); end
  endtask

  task automatic test_contention();
    int bad = 0;
    sel = 0;
    do_reset();
    req_0 = 1'b1; req_1 = 1'b1;
    pulse_start();
    run_capture(600, 60);
    req_0 = 1'b0; req_1 = 1'b0;
    for (int k = 0; k < grants.size(); k++) if (grants[k] != (k % 2)) bad++;
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL cont_timeout: no done within budget"); end
    n_tests++; if (grants.size() != 8 || bad != 0) begin n_fail++; $display("FAIL cont_grants: %0d bursts %0d out of order want 8/0", grants.size(), bad); end
    n_tests++; if (addr_at_done != 200) begin n_fail++; $display("FAIL cont_addr: got %0d want 200", addr_at_done); end
    n_tests++; if (min_gap < 3) begin n_fail++; $display("FAIL cont_gap: got %0d want >=3", min_gap); end
    n_tests++; if (both_en) begin n_fail++; $display("FAIL cont_exclusive: both weight_en high"); end
    n_tests++; if (en0_count != 100 || en1_count != 100) begin n_fail++; $display("FAIL cont_en_counts: en0=%0d en1=%0d want 100/100", en0_count, en1_count); end
    n_tests++; if (stream_bad(0, 1024) != 0) begin n_fail++; $display("FAIL cont_stream: %0d bad bits want 0", stream_bad(0, 1024)); end
  endtask

  task automatic test_late_request();
    int bad = 0;
    sel = 1;
    do_reset();
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!(m_busy === 1'b1 && m_rd === 1'b0)) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL late_wait: %0d bad cycles want 0", bad); end
    req_1 = 1'b1;
    run_capture(200, -1);
    req_1 = 1'b0;
    n_tests++; if (grants.size() != 1 || en1_count != 25 || en0_count != 0) begin
      n_fail++; $display("FAIL late_load: bursts=%0d en1=%0d en0=%0d want 1/25/0", grants.size(), en1_count, en0_count); end
    n_tests++; if (addr_at_done != 25 || done_cycles != 1) begin
      n_fail++; $display("FAIL late_done: addr=%0d done=%0d want 25/1", addr_at_done, done_cycles); end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    int bad = 0;
    sel = 0;
    do_reset();
    req_0 = 1'b1;
    pulse_start();
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (m_rd && m_addr == 10'd12) found = 1'b1;
    end
    n_tests++; if (!found || m_en0 !== 1'b1) begin n_fail++; $display("FAIL abort_reach: found=%b en0=%b want 1/1", found, m_en0); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++; if ({m_rd, m_en0, m_en1, m_busy, m_done} !== 5'd0) begin
      n_fail++; $display("FAIL abort_drop: rd=%b en0=%b en1=%b busy=%b done=%b want 0", m_rd, m_en0, m_en1, m_busy, m_done); end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (m_done || m_busy || m_en0 || m_rd) bad++;
    end
    n_tests++; if (bad != 0 || m_addr !== 10'd12) begin n_fail++; $display("FAIL abort_hold: addr=%0d bad=%0d want 12/0", m_addr, bad); end
    req_0 = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bit found = 1'b0;
    int bad = 0;
    sel = 1;
    do_reset();
    req_0 = 1'b1;
    pulse_start();
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (m_rd && m_addr == 10'd12) found = 1'b1;
    end
    #1 rstn = 1'b0;
    #1;
    n_tests++; if (!found || {m_rd, m_addr, m_out, m_en0, m_en1, m_busy, m_done} !== 16'd0) begin
      n_fail++; $display("FAIL midreset_async: found=%b rd=%b addr=%0d en0=%b busy=%b want 1/0/0/0/0", found, m_rd, m_addr, m_en0, m_busy); end
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (m_en0 || m_en1 || m_rd) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL midreset_residue: %0d bad cycles want 0", bad); end
    pulse_start();
    run_capture(200, -1);
    req_0 = 1'b0;
    n_tests++; if (rd_addr.size() != 25 || stream_bad(0, 1024) != 0 || done_cycles != 1) begin
      n_fail++; $display("FAIL midreset_reload: rd=%0d bad=%0d done=%0d want 25/0/1", rd_addr.size(), stream_bad(0, 1024), done_cycles); end
  endtask

  task automatic test_addr_wrap();
    sel = 2;
    do_reset();
    req_0 = 1'b1;
    pulse_start();
    run_capture(200, -1);
    req_0 = 1'b0;
    n_tests++; if (rd_addr.size() != 25 || stream_bad(0, 16) != 0) begin
      n_fail++; $display("FAIL wrap_stream: rd=%0d bad=%0d want 25/0", rd_addr.size(), stream_bad(0, 16)); end
    n_tests++; if (addr_at_done != 9) begin n_fail++; $display("FAIL wrap_final_addr: got %0d want 9", addr_at_done); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_late_request();
    test_abort();
    test_reset_mid_op();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
